// File: rtl/any1_lsu.sv
// any1_lsu: load/store unit between the address generator and a 64-bit
// Wishbone-classic data bus. Accepts one op at a time (req_ready only in IDLE),
// splits accesses that cross an 8-byte boundary into two bus cycles, and
// returns aligned/extended load data with the request tag.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_*                request from address generator (valid/ready)
//   cyc_o..dat_o, ack_i, err_i, dat_i   Wishbone-classic master
//   res_*                one-cycle tagged result pulse to writeback
// Latency: accept + bus wait cycles + 1; split ops add a strobe gap cycle.
module any1_lsu #(
   parameter int AWID    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_st,
   input  logic [1:0]      req_size,
   input  logic            req_sext,
   input  logic [AWID-1:0] req_ea,
   input  logic [63:0]     req_data,
   input  logic [5:0]      req_tag,
   output logic            cyc_o,
   output logic            stb_o,
   output logic            we_o,
   output logic [7:0]      sel_o,
   output logic [AWID-1:0] adr_o,
   output logic [63:0]     dat_o,
   input  logic            ack_i,
   input  logic            err_i,
   input  logic [63:0]     dat_i,
   output logic            res_valid,
   output logic [5:0]      res_tag,
   output logic [63:0]     res_data,
   output logic            res_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUS1 = 2'd1;
   localparam logic [1:0] BUS2 = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   // Last wait-count value before the cycle is abandoned as a timeout.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state;
   logic [2:0]  off_r;
   logic [1:0]  size_r;
   logic        sext_r;
   logic        st_r;
   logic        split_r;
   logic [5:0]  tag_r;
   logic [7:0]  sel_hi;
   logic [63:0] dat_hi;
   logic [63:0] buf_lo;
   logic [7:0]  tmo;

   // Request decode
   logic [2:0]   req_off;
   logic [3:0]   req_n;
   logic [7:0]   req_bm;
   logic [15:0]  req_mask16;
   logic [127:0] req_data128;
   logic         req_split;

   always_comb begin
      req_off     = req_ea[2:0];
      req_n       = 4'd1 << req_size;
      case (req_size)
         2'd0:    req_bm = 8'h01;
         2'd1:    req_bm = 8'h03;
         2'd2:    req_bm = 8'h0F;
         default: req_bm = 8'hFF;
      endcase
      req_mask16  = {8'h00, req_bm} << req_off;
      req_data128 = {64'h0, req_data} << {req_off, 3'b000};
      req_split   = ({1'b0, req_off} + req_n) > 4'd8;
   end

   // Bus handshake: the strobe-low gap cycle in BUS2 neither waits nor
   // observes ack_i/err_i. err_i beats ack_i when both are high.
   logic bus_active, tmo_hit, bus_err, bus_ack, fin;
   always_comb begin
      bus_active = ((state == BUS1) || (state == BUS2)) && stb_o;
      tmo_hit    = bus_active && !ack_i && !err_i && (tmo == TMO_LAST);
      bus_err    = bus_active && (err_i || tmo_hit);
      bus_ack    = bus_active && ack_i && !err_i;
      fin        = bus_ack && ((state == BUS2) || !split_r);
   end

   // Load alignment uses the buffer as it will be after this ack.
   logic [127:0] ld_buf;
   logic [63:0]  ld_raw;
   logic [63:0]  ld_ext;
   always_comb begin
      ld_buf = (state == BUS2) ? {dat_i, buf_lo} : {64'h0, dat_i};
      ld_raw = ld_buf[{off_r, 3'b000} +: 64];
      case (size_r)
         2'd0:    ld_ext = {{56{sext_r & ld_raw[7]}},  ld_raw[7:0]};
         2'd1:    ld_ext = {{48{sext_r & ld_raw[15]}}, ld_raw[15:0]};
         2'd2:    ld_ext = {{32{sext_r & ld_raw[31]}}, ld_raw[31:0]};
         default: ld_ext = ld_raw;
      endcase
   end

   assign req_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cyc_o     <= 1'b0;
         stb_o     <= 1'b0;
         we_o      <= 1'b0;
         sel_o     <= 8'h00;
         adr_o     <= '0;
         dat_o     <= 64'h0;
         res_valid <= 1'b0;
         res_err   <= 1'b0;
         res_data  <= 64'h0;
         res_tag   <= 6'h00;
         off_r     <= 3'd0;
         size_r    <= 2'd0;
         sext_r    <= 1'b0;
         st_r      <= 1'b0;
         split_r   <= 1'b0;
         tag_r     <= 6'h00;
         sel_hi    <= 8'h00;
         dat_hi    <= 64'h0;
         buf_lo    <= 64'h0;
         tmo       <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  off_r   <= req_off;
                  size_r  <= req_size;
                  sext_r  <= req_sext;
                  st_r    <= req_st;
                  split_r <= req_split;
                  tag_r   <= req_tag;
                  sel_hi  <= req_mask16[15:8];
                  dat_hi  <= req_data128[127:64];
                  cyc_o   <= 1'b1;
                  stb_o   <= 1'b1;
                  we_o    <= req_st;
                  adr_o   <= {req_ea[AWID-1:3], 3'b000};
                  sel_o   <= req_mask16[7:0];
                  dat_o   <= req_data128[63:0];
                  tmo     <= 8'h00;
                  state   <= BUS1;
               end
            end
            BUS1, BUS2: begin
               if ((state == BUS2) && !stb_o) begin
                  // End of the one-cycle strobe gap: start the second cycle.
                  stb_o <= 1'b1;
                  tmo   <= 8'h00;
               end else if (bus_err || fin) begin
                  cyc_o     <= 1'b0;
                  stb_o     <= 1'b0;
                  we_o      <= 1'b0;
                  res_valid <= 1'b1;
                  res_tag   <= tag_r;
                  res_err   <= bus_err;
                  res_data  <= (bus_err || st_r) ? 64'h0 : ld_ext;
                  state     <= DONE;
               end else if (bus_ack) begin
                  // First half of a split: address wraps modulo 2^AWID.
                  buf_lo <= dat_i;
                  stb_o  <= 1'b0;
                  adr_o  <= adr_o + AWID'(8);
                  sel_o  <= sel_hi;
                  dat_o  <= dat_hi;
                  state  <= BUS2;
               end else if (bus_active) begin
                  tmo <= tmo + 8'd1;
               end
            end
            default: begin
               res_valid <= 1'b0;
               res_err   <= 1'b0;
               res_data  <= 64'h0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_any1_lsu.sv
// Directed testbench for any1_lsu (TIMEOUT=4). Inputs are driven and outputs
// sampled on the falling edge of clk.
module tb_any1_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_st;
   logic [1:0]  req_size;
   logic        req_sext;
   logic [31:0] req_ea;
   logic [63:0] req_data;
   logic [5:0]  req_tag;
   logic        cyc_o, stb_o, we_o;
   logic [7:0]  sel_o;
   logic [31:0] adr_o;
   logic [63:0] dat_o;
   logic        ack_i, err_i;
   logic [63:0] dat_i;
   logic        res_valid;
   logic [5:0]  res_tag;
   logic [63:0] res_data;
   logic        res_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   any1_lsu #(.AWID(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_st(req_st),
      .req_size(req_size), .req_sext(req_sext), .req_ea(req_ea),
      .req_data(req_data), .req_tag(req_tag),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
      .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .err_i(err_i),
      .dat_i(dat_i),
      .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
      .res_err(res_err)
   );

   // Presents one request for a single cycle; returns at the falling edge
   // after the accepting edge (first BUS1 cycle).
   task automatic issue(input logic st, input logic [1:0] size, input logic sext,
                        input logic [31:0] ea, input logic [63:0] data,
                        input logic [5:0] tag);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL issue_ready got %b exp 1", req_ready);
      end
      req_valid = 1'b1; req_st = st; req_size = size; req_sext = sext;
      req_ea = ea; req_data = data; req_tag = tag;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Acks the current bus cycle with read data, returns one cycle later.
   task automatic ack_now(input logic [63:0] rd);
      ack_i = 1'b1; dat_i = rd;
      @(negedge clk);
      ack_i = 1'b0; dat_i = 64'h0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({cyc_o, stb_o, we_o, res_valid, res_err} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 00000", {cyc_o, stb_o, we_o, res_valid, res_err}); end
      checks++; if ({sel_o, adr_o, dat_o} !== 104'h0) begin
         errors++; $display("FAIL reset_bus got sel %h adr %h dat %h exp 0", sel_o, adr_o, dat_o); end
      checks++; if (res_data !== 64'h0 || res_tag !== 6'h0) begin
         errors++; $display("FAIL reset_res got %h/%h exp 0/0", res_data, res_tag); end
      checks++; if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      rst = 1'b0;
      // A stray ack while idle must not produce anything.
      @(negedge clk); ack_i = 1'b1;
      @(negedge clk); ack_i = 1'b0;
      checks++; if (res_valid !== 1'b0 || cyc_o !== 1'b0) begin
         errors++; $display("FAIL idle_ack got valid %b cyc %b exp 0 0", res_valid, cyc_o); end
   endtask

   task automatic test_octa_load;
      issue(1'b0, 2'd3, 1'b0, 32'h1000, 64'h0, 6'd5);
      checks++; if ({cyc_o, stb_o, we_o} !== 3'b110 || adr_o !== 32'h1000 || sel_o !== 8'hFF) begin
         errors++; $display("FAIL octa_bus got cyc/stb/we %b adr %h sel %h exp 110 1000 ff", {cyc_o, stb_o, we_o}, adr_o, sel_o); end
      checks++; if (res_valid !== 1'b0) begin
         errors++; $display("FAIL octa_early got %b exp 0", res_valid); end
      ack_now(64'h8877665544332211);
      checks++; if (res_valid !== 1'b1 || res_data !== 64'h8877665544332211 || res_tag !== 6'd5 || res_err !== 1'b0) begin
         errors++; $display("FAIL octa_res got v %b d %h t %0d e %b exp 1 8877665544332211 5 0", res_valid, res_data, res_tag, res_err); end
      checks++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin
         errors++; $display("FAIL octa_drop got cyc %b stb %b exp 0 0", cyc_o, stb_o); end
      @(negedge clk);
      checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL octa_pulse got v %b rdy %b exp 0 1", res_valid, req_ready); end
   endtask

   task automatic test_byte_load;
      issue(1'b0, 2'd0, 1'b1, 32'h1003, 64'h0, 6'd9);
      checks++; if (sel_o !== 8'h08 || adr_o !== 32'h1000) begin
         errors++; $display("FAIL byte_sel got %h adr %h exp 08 1000", sel_o, adr_o); end
      ack_now(64'h11223344_80667788);
      checks++; if (res_valid !== 1'b1 || res_data !== 64'hFFFFFFFFFFFFFF80) begin
         errors++; $display("FAIL byte_sext got v %b d %h exp 1 ffffffffffffff80", res_valid, res_data); end
      issue(1'b0, 2'd0, 1'b0, 32'h1003, 64'h0, 6'd10);
      ack_now(64'h11223344_80667788);
      checks++; if (res_valid !== 1'b1 || res_data !== 64'h80 || res_tag !== 6'd10) begin
         errors++; $display("FAIL byte_zext got v %b d %h t %0d exp 1 80 10", res_valid, res_data, res_tag); end
   endtask

   task automatic test_split_store;
      issue(1'b1, 2'd2, 1'b0, 32'h1006, 64'hAABBCCDD, 6'd17);
      checks++; if (we_o !== 1'b1 || adr_o !== 32'h1000 || sel_o !== 8'hC0 || dat_o[63:48] !== 16'hCCDD) begin
         errors++; $display("FAIL sst_c1 got we %b adr %h sel %h d %h exp 1 1000 c0 ccdd", we_o, adr_o, sel_o, dat_o[63:48]); end
      ack_now(64'h0);
      checks++; if (cyc_o !== 1'b1 || stb_o !== 1'b0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL sst_gap got cyc %b stb %b v %b exp 1 0 0", cyc_o, stb_o, res_valid); end
      @(negedge clk);
      checks++; if (stb_o !== 1'b1 || adr_o !== 32'h1008 || sel_o !== 8'h03 || dat_o[15:0] !== 16'hAABB) begin
         errors++; $display("FAIL sst_c2 got stb %b adr %h sel %h d %h exp 1 1008 03 aabb", stb_o, adr_o, sel_o, dat_o[15:0]); end
      ack_now(64'hFFFF_FFFF_FFFF_FFFF);
      checks++; if (res_valid !== 1'b1 || res_data !== 64'h0 || res_tag !== 6'd17 || cyc_o !== 1'b0) begin
         errors++; $display("FAIL sst_res got v %b d %h t %0d cyc %b exp 1 0 17 0", res_valid, res_data, res_tag, cyc_o); end
   endtask

   task automatic test_split_load;
      issue(1'b0, 2'd1, 1'b0, 32'h2007, 64'h0, 6'd33);
      checks++; if (adr_o !== 32'h2000 || sel_o !== 8'h80) begin
         errors++; $display("FAIL sld_c1 got adr %h sel %h exp 2000 80", adr_o, sel_o); end
      ack_now(64'h34000000_00000000);
      @(negedge clk);
      checks++; if (adr_o !== 32'h2008 || sel_o !== 8'h01 || stb_o !== 1'b1) begin
         errors++; $display("FAIL sld_c2 got adr %h sel %h stb %b exp 2008 01 1", adr_o, sel_o, stb_o); end
      ack_now(64'h00000000_00000012);
      checks++; if (res_valid !== 1'b1 || res_data !== 64'h1234) begin
         errors++; $display("FAIL sld_res got v %b d %h exp 1 1234", res_valid, res_data); end
   endtask

   task automatic test_error;
      // err_i together with ack_i on the first half: err wins, no second cycle.
      issue(1'b0, 2'd3, 1'b0, 32'h100C, 64'h0, 6'd40);
      err_i = 1'b1;
      ack_now(64'h0);
      err_i = 1'b0;
      checks++; if (res_valid !== 1'b1 || res_err !== 1'b1 || cyc_o !== 1'b0 || res_tag !== 6'd40) begin
         errors++; $display("FAIL err_res got v %b e %b cyc %b t %0d exp 1 1 0 40", res_valid, res_err, cyc_o, res_tag); end
      @(negedge clk);
      checks++; if (res_valid !== 1'b0 || res_err !== 1'b0 || cyc_o !== 1'b0) begin
         errors++; $display("FAIL err_after got v %b e %b cyc %b exp 0 0 0", res_valid, res_err, cyc_o); end
   endtask

   task automatic test_timeout;
      int early = 0;
      issue(1'b0, 2'd3, 1'b0, 32'h3000, 64'h0, 6'd44);
      // First wait cycle is now; three more must still show the cycle open.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (cyc_o !== 1'b1 || res_valid !== 1'b0) early++;
      end
      checks++; if (early != 0) begin
         errors++; $display("FAIL tmo_wait got %0d early ends exp 0", early); end
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_err !== 1'b1 || cyc_o !== 1'b0) begin
         errors++; $display("FAIL tmo_res got v %b e %b cyc %b exp 1 1 0", res_valid, res_err, cyc_o); end
   endtask

   task automatic test_reset_mid;
      int spurious = 0;
      issue(1'b0, 2'd3, 1'b0, 32'h5000, 64'h0, 6'd50);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin
         errors++; $display("FAIL rstmid_drop got cyc %b stb %b exp 0 0", cyc_o, stb_o); end
      ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (res_valid !== 1'b0) spurious++;
         @(negedge clk);
         ack_i = 1'b0;
      end
      checks++; if (spurious != 0) begin
         errors++; $display("FAIL rstmid_res got %0d pulses exp 0", spurious); end
      issue(1'b1, 2'd3, 1'b0, 32'h4000, 64'h0123456789ABCDEF, 6'd51);
      checks++; if (we_o !== 1'b1 || dat_o !== 64'h0123456789ABCDEF || sel_o !== 8'hFF) begin
         errors++; $display("FAIL rstmid_st got we %b d %h sel %h exp 1 0123456789abcdef ff", we_o, dat_o, sel_o); end
      ack_now(64'h0);
      checks++; if (res_valid !== 1'b1 || res_tag !== 6'd51 || res_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_res2 got v %b t %0d e %b exp 1 51 0", res_valid, res_tag, res_err); end
   endtask

   task automatic test_wrap;
      issue(1'b0, 2'd3, 1'b0, 32'hFFFFFFFC, 64'h0, 6'd60);
      checks++; if (adr_o !== 32'hFFFFFFF8 || sel_o !== 8'hF0) begin
         errors++; $display("FAIL wrap_c1 got adr %h sel %h exp fffffff8 f0", adr_o, sel_o); end
      ack_now(64'hDDCCBBAA_00000000);
      @(negedge clk);
      checks++; if (adr_o !== 32'h0 || sel_o !== 8'h0F) begin
         errors++; $display("FAIL wrap_c2 got adr %h sel %h exp 0 0f", adr_o, sel_o); end
      ack_now(64'h00000000_44332211);
      checks++; if (res_valid !== 1'b1 || res_data !== 64'h44332211DDCCBBAA) begin
         errors++; $display("FAIL wrap_res got v %b d %h exp 1 44332211ddccbbaa", res_valid, res_data); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_st = 1'b0; req_size = 2'd0;
      req_sext = 1'b0; req_ea = 32'h0; req_data = 64'h0; req_tag = 6'h0;
      ack_i = 1'b0; err_i = 1'b0; dat_i = 64'h0;
      test_reset;
      test_octa_load;
      test_byte_load;
      test_split_store;
      test_split_load;
      test_error;
      test_timeout;
      test_reset_mid;
      test_wrap;
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
